// File: rtl/nibble_add_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// add_seq_pkg
// Shared definitions for the nibble-serial add/subtract sequencer:
//   - NIB_W     : width of the single adder slice (one nibble)
//   - state_t   : sequencer state encoding (IDLE / RUN / DONE)
//   - idx_width : width of the nibble index counter, never less than 1 bit
// ---------------------------------------------------------------------------
package add_seq_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // clog2(nib) with a floor of one bit so a single-nibble build still
    // has a legal counter.
    function automatic int idx_width(input int nib);
        return (nib <= 2) ? 1 : $clog2(nib);
    endfunction

endpackage

// File: rtl/nibble_add_sequencer_if.sv
// ---------------------------------------------------------------------------
// nibble_add_sequencer_if
// Operand/result handshake bundle for nibble_add_sequencer.
//   operand side : in_valid, in_ready, a, b, cin, sub
//   result side  : out_valid, out_ready, sum, cout, ovf
//   status       : busy
// master = producer/consumer around the block, slave = the sequencer itself.
// ---------------------------------------------------------------------------
interface nibble_add_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );

endinterface

// File: rtl/nibble_add_sequencer_rca4.sv
// ---------------------------------------------------------------------------
// ripplecarryadder_4
// Purely combinational 4-bit ripple-carry adder; the only arithmetic slice
// used by the sequencer.
//   a, b  : nibble operands
//   Cin   : carry into bit 0
//   sum   : nibble sum
//   carry : carry out of bit 3
// ---------------------------------------------------------------------------
module ripplecarryadder_4
    import add_seq_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             Cin,
    output logic [NIB_W-1:0] sum,
    output logic             carry
);

    logic [NIB_W:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign carry = c[NIB_W];

endmodule

// File: rtl/nibble_add_sequencer.sv
// ---------------------------------------------------------------------------
// nibble_add_sequencer
// Adds (or subtracts) two WIDTH-bit operands through one 4-bit ripple-carry
// slice, one nibble per cycle, LSB nibble first, with the carry registered
// between nibbles. WIDTH must be a multiple of 4 and at least 4; it must match
// the WIDTH of the connected interface.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, discards any in-flight operation
//   bus  : operand/result handshake (see nibble_add_sequencer_if)
// Result is valid NIB cycles after the operand handshake; sum/cout/ovf only
// change on the final nibble edge (or reset).
// ---------------------------------------------------------------------------
module nibble_add_sequencer
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    nibble_add_sequencer_if.slave  bus
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = idx_width(NIB);

    state_t             state;
    state_t             state_nxt;

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   sum_reg;    // partial result, shifted in from the top
    logic [WIDTH-1:0]   sum_q;      // visible result, updated once per op
    logic               carry_reg;
    logic               cout_q;
    logic               ovf_q;
    logic               a_msb;
    logic               b_msb;
    logic [IDX_W-1:0]   nib_idx;

    logic [WIDTH-1:0]   b_eff;
    logic [NIB_W-1:0]   nib_sum;
    logic               nib_carry;
    logic [WIDTH-1:0]   sum_shift;
    logic               last_nib;

    // Subtraction is a + ~b + 1; the +1 comes in through the carry register.
    assign b_eff    = bus.sub ? ~bus.b : bus.b;
    assign last_nib = (nib_idx == IDX_W'(NIB - 1));

    ripplecarryadder_4 u_adder (
        .a     (a_reg[NIB_W-1:0]),
        .b     (b_reg[NIB_W-1:0]),
        .Cin   (carry_reg),
        .sum   (nib_sum),
        .carry (nib_carry)
    );

    // Each new nibble lands in the top of the partial sum; after NIB shifts
    // the first nibble has reached bit 0.
    if (NIB == 1) begin : g_single
        assign sum_shift = nib_sum;
    end else begin : g_multi
        assign sum_shift = {nib_sum, sum_reg[WIDTH-1:NIB_W]};
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and handshake outputs
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;

        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last_nib) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                // Return to IDLE only; in_ready rises the following cycle.
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    // NOTE: with a synchronous reset, every datapath register is cleared
    // explicitly; there is no storage array here that would need exempting.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            sum_q     <= '0;
            carry_reg <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            nib_idx   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg     <= bus.a;
                        b_reg     <= b_eff;
                        carry_reg <= bus.sub | bus.cin;
                        nib_idx   <= '0;
                        a_msb     <= bus.a[WIDTH-1];
                        b_msb     <= b_eff[WIDTH-1];
                    end
                end
                RUN: begin
                    sum_reg   <= sum_shift;
                    a_reg     <= a_reg >> NIB_W;
                    b_reg     <= b_reg >> NIB_W;
                    carry_reg <= nib_carry;
                    nib_idx   <= nib_idx + 1'b1;
                    if (last_nib) begin
                        sum_q  <= sum_shift;
                        cout_q <= nib_carry;
                        // Signed overflow: like-signed operands, result sign differs.
                        ovf_q  <= (a_msb == b_msb) && (nib_sum[NIB_W-1] != a_msb);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule
